firebird7_in_gate2_sri_reset_sequencer: RTL and testbench
=========================================================

# firebird7_in_gate2_sri_reset_sequencer

Sideband-reset (SRI) sequencer that sits directly downstream of the gate2 SRI TDR. It consumes the TDR's 1-bit active-low request output (`sri_req_n`, reset value 1). Each new request produces one timed reset pulse to the target logic, followed by a settle window and a completion status. It also keeps a saturating count of completed sequences for capture by a status TDR.

## Interface
Parameters:
- `ASSERT_CYCLES`, default 4: `ijtag_tck` cycles `sri_reset_n` is held low. Legal range ≥1.
- `RELEASE_CYCLES`, default 8: settle cycles after release, before done. Legal range ≥1.
- `CNT_W`, default 4: width of the completed-sequence counter.

Ports:
- `ijtag_tck`, input, 1: sole clock; all state on posedge.
- `ijtag_reset`, input, 1: asynchronous, active-high reset.
- `sri_req_n`, input, 1: request from the SRI TDR data-out. 0 = request, 1 = idle. Changes on the negedge of `ijtag_tck`.
- `sri_reset_n`, output, 1: registered active-low reset to the target.
- `sri_busy`, output, 1: high in ASSERT and RELEASE.
- `sri_done`, output, 1: high in DONE.
- `sri_count`, output, `CNT_W`: completed sequences, saturating.
- `sri_status`, output, 2: state encoding for capture. IDLE=00, ASSERT=01, RELEASE=10, DONE=11.

## Operation
- `req_q` register samples `sri_req_n` every posedge; reset value 1.
- Request edge: `req_q`==1 and `sri_req_n`==0 at the same posedge. A level 0 without a preceding 1 is not a request.
- Single down-counter `tmr`, width `$clog2(max(ASSERT_CYCLES,RELEASE_CYCLES)+1)`.

State machine:
- IDLE → ASSERT on a request edge. Load `tmr`=`ASSERT_CYCLES`-1; `sri_reset_n`←0.
- ASSERT: while `tmr`≠0, decrement. When `tmr`==0: → RELEASE, `sri_reset_n`←1, load `tmr`=`RELEASE_CYCLES`-1.
- RELEASE: while `tmr`≠0, decrement. When `tmr`==0: → DONE, and `sri_count` increments unless already all-ones (saturates, no wrap).
- DONE: stay while `sri_req_n`==0. On a posedge sampling `sri_req_n`==1, → IDLE.

Boundary rules:
- A sequence is never aborted by the request. `sri_req_n` returning to 1 during ASSERT or RELEASE is ignored; the sequence completes, then DONE exits on the first posedge after entry that samples 1.
- A request edge seen in any state other than IDLE is dropped; there is no queuing. `req_q` still tracks the input.
- `ijtag_reset` mid-sequence: everything returns immediately to reset values. `sri_reset_n` goes to 1 asynchronously, the count clears, and the sequence is not completed.
- `ASSERT_CYCLES`=1 or `RELEASE_CYCLES`=1: a single-cycle phase, with `tmr` loaded as 0.

## Timing
- Reset values: `sri_reset_n`=1, `sri_busy`=0, `sri_done`=0, `sri_count`=0, `sri_status`=00, `req_q`=1, `tmr`=0.
- Let posedge k be the one that detects the request edge.
- `sri_reset_n` is low from edge k to edge k+`ASSERT_CYCLES`: exactly `ASSERT_CYCLES` cycles.
- `sri_busy` is high from edge k to edge k+`ASSERT_CYCLES`+`RELEASE_CYCLES`.
- `sri_done` and the count increment take effect at edge k+`ASSERT_CYCLES`+`RELEASE_CYCLES`.
- DONE→IDLE takes effect on the posedge that samples `sri_req_n`==1. The minimum DONE duration is 1 cycle.
- The earliest next request edge is the posedge after IDLE is entered at which `sri_req_n` is sampled 0.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset: assert `ijtag_reset` with the clock stopped. Required: `sri_reset_n`=1, busy=0, done=0, count=0, status=00 immediately.
- Nominal (A=4, R=8): drive `sri_req_n` 1→0 sampled at edge 10, then hold 0.
  - `sri_reset_n` is low on edges 10–13 and high from 14.
  - busy is high on edges 10–21.
  - done=1 and count=1 at edge 22.
  - Raise `sri_req_n` at edge 30; required: status=00 at edge 30.
- Early withdraw: `sri_req_n` returns to 1 two cycles after the request. Required: the full 4-cycle low pulse and 8-cycle settle still occur, DONE lasts exactly 1 cycle, and count increments.
- Dropped request: toggle `sri_req_n` 0→1→0 during RELEASE. Required: no second pulse and count +1 only.
- Reset mid-ASSERT: assert `ijtag_reset` at cycle 2 of ASSERT. Required: `sri_reset_n`=1 asynchronously, count=0, and a new request starts a full pulse.
- Saturation and A=R=1: run 17 sequences with `CNT_W`=4. Required: `sri_count` stops at 15. With A=R=1, the low pulse is 1 cycle and done comes 2 cycles after the request edge.

Source files
------------

// File: rtl/firebird7_in_gate2_sri_reset_sequencer_if.sv
// Sideband-reset request/status bundle between the gate2 SRI TDR and its reset sequencer.
// master = TDR/status side (drives the request), slave = sequencer.
interface firebird7_in_gate2_sri_reset_sequencer_if #(
    parameter int unsigned CNT_W = 4
) ();

    logic             sri_req_n;
    logic             sri_reset_n;
    logic             sri_busy;
    logic             sri_done;
    logic [CNT_W-1:0] sri_count;
    logic [1:0]       sri_status;

    modport master (
        output sri_req_n,
        input  sri_reset_n,
        input  sri_busy,
        input  sri_done,
        input  sri_count,
        input  sri_status
    );

    modport slave (
        input  sri_req_n,
        output sri_reset_n,
        output sri_busy,
        output sri_done,
        output sri_count,
        output sri_status
    );

endinterface

// File: rtl/firebird7_in_gate2_sri_reset_sequencer.sv
// Turns each falling edge of the SRI TDR request into one timed active-low reset pulse,
// a settle window and a DONE status, with a saturating count of completed sequences.
module firebird7_in_gate2_sri_reset_sequencer #(
    parameter int unsigned ASSERT_CYCLES  = 4,
    parameter int unsigned RELEASE_CYCLES = 8,
    parameter int unsigned CNT_W          = 4
) (
    input logic                                    ijtag_tck,
    input logic                                    ijtag_reset,
    firebird7_in_gate2_sri_reset_sequencer_if.slave sri
);

    localparam int unsigned MaxCycles = (ASSERT_CYCLES > RELEASE_CYCLES) ? ASSERT_CYCLES
                                                                         : RELEASE_CYCLES;
    localparam int unsigned TmrW      = $clog2(MaxCycles + 1);

    localparam logic [TmrW-1:0] AssertLoad  = TmrW'(ASSERT_CYCLES - 1);
    localparam logic [TmrW-1:0] ReleaseLoad = TmrW'(RELEASE_CYCLES - 1);

    // Encoding doubles as the captured status word.
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAssert  = 2'b01,
        StRelease = 2'b10,
        StDone    = 2'b11
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic             r_req_q;
    logic [TmrW-1:0]  r_tmr;
    logic [TmrW-1:0]  w_tmr_d;
    logic             r_reset_n;
    logic             w_reset_n_d;
    logic             r_busy;
    logic             w_busy_d;
    logic             r_done;
    logic             w_done_d;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_d;
    logic             w_req_edge;

    // A held-low level never counts as a request; only a 1 -> 0 transition does.
    assign w_req_edge = r_req_q & ~sri.sri_req_n;

    always_comb begin
        w_state_d   = r_state;
        w_tmr_d     = r_tmr;
        w_reset_n_d = r_reset_n;
        w_count_d   = r_count;

        case (r_state)
            StIdle: begin
                if (w_req_edge) begin
                    w_state_d   = StAssert;
                    w_tmr_d     = AssertLoad;
                    w_reset_n_d = 1'b0;
                end
            end
            StAssert: begin
                if (r_tmr != '0) begin
                    w_tmr_d = r_tmr - 1'b1;
                end else begin
                    w_state_d   = StRelease;
                    w_tmr_d     = ReleaseLoad;
                    w_reset_n_d = 1'b1;
                end
            end
            StRelease: begin
                if (r_tmr != '0) begin
                    w_tmr_d = r_tmr - 1'b1;
                end else begin
                    w_state_d = StDone;
                    if (!(&r_count)) begin
                        w_count_d = r_count + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                if (sri.sri_req_n) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_tmr_d     = '0;
                w_reset_n_d = 1'b1;
            end
        endcase

        w_busy_d = (w_state_d == StAssert) || (w_state_d == StRelease);
        w_done_d = (w_state_d == StDone);
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            r_state   <= StIdle;
            r_req_q   <= 1'b1;
            r_tmr     <= '0;
            r_reset_n <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_req_q   <= sri.sri_req_n;
            r_tmr     <= w_tmr_d;
            r_reset_n <= w_reset_n_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_count   <= w_count_d;
        end
    end

    assign sri.sri_reset_n = r_reset_n;
    assign sri.sri_busy    = r_busy;
    assign sri.sri_done    = r_done;
    assign sri.sri_count   = r_count;
    assign sri.sri_status  = r_state;

endmodule

// File: tb/tb_firebird7_in_gate2_sri_reset_sequencer.sv
// Directed bench for the SRI reset sequencer: A=4/R=8 instance plus an A=R=1 instance.
module tb_firebird7_in_gate2_sri_reset_sequencer;

    localparam int unsigned A  = 4;
    localparam int unsigned R  = 8;
    localparam int unsigned CW = 4;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst    = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   edge_num = 0;

    firebird7_in_gate2_sri_reset_sequencer_if #(.CNT_W(CW)) bus ();
    firebird7_in_gate2_sri_reset_sequencer_if #(.CNT_W(CW)) bus1 ();

    firebird7_in_gate2_sri_reset_sequencer #(
        .ASSERT_CYCLES  (A),
        .RELEASE_CYCLES (R),
        .CNT_W          (CW)
    ) dut (
        .ijtag_tck   (clk),
        .ijtag_reset (rst),
        .sri         (bus)
    );

    firebird7_in_gate2_sri_reset_sequencer #(
        .ASSERT_CYCLES  (1),
        .RELEASE_CYCLES (1),
        .CNT_W          (CW)
    ) dut1 (
        .ijtag_tck   (clk),
        .ijtag_reset (rst),
        .sri         (bus1)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
        edge_num++;
    endtask

    task automatic set_req(input logic v);
        @(negedge clk);
        bus.sri_req_n = v;
    endtask

    // pat[i] is the request level sampled at edge k+i, k being the request edge (pat[0] = 0).
    task automatic seq(input string tag, input logic [15:0] pat, input int exp_cnt);
        for (int i = 0; i <= int'(A + R); i++) begin
            set_req(pat[i]);
            next_edge();
            if (i < int'(A + R)) begin
                chk({tag, "/reset_n"}, 8'(bus.sri_reset_n), (i < int'(A)) ? 8'd0 : 8'd1);
                chk({tag, "/busy"},    8'(bus.sri_busy),    8'd1);
                chk({tag, "/done"},    8'(bus.sri_done),    8'd0);
                chk({tag, "/status"},  8'(bus.sri_status),  (i < int'(A)) ? 8'd1 : 8'd2);
            end else begin
                chk({tag, "/end_reset_n"}, 8'(bus.sri_reset_n), 8'd1);
                chk({tag, "/end_busy"},    8'(bus.sri_busy),    8'd0);
                chk({tag, "/end_done"},    8'(bus.sri_done),    8'd1);
                chk({tag, "/end_status"},  8'(bus.sri_status),  8'd3);
                chk({tag, "/end_count"},   8'(bus.sri_count),   8'(exp_cnt));
            end
        end
    endtask

    initial begin
        bus.sri_req_n  = 1'b1;
        bus1.sri_req_n = 1'b1;

        // Reset with the clock stopped.
        #1 rst = 1'b1;
        #1;
        chk("rst/reset_n", 8'(bus.sri_reset_n), 8'd1);
        chk("rst/busy",    8'(bus.sri_busy),    8'd0);
        chk("rst/done",    8'(bus.sri_done),    8'd0);
        chk("rst/count",   8'(bus.sri_count),   8'd0);
        chk("rst/status",  8'(bus.sri_status),  8'd0);
        chk("rst/count1",  8'(bus1.sri_count),  8'd0);

        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        edge_num = 0;

        // Nominal: request sampled at edge 10, held low.
        repeat (9) next_edge();
        chk("idle/status", 8'(bus.sri_status), 8'd0);
        seq("nom", 16'h0000, 1);
        for (int i = 23; i < 30; i++) begin
            set_req(1'b0);
            next_edge();
            chk("nom/hold_done",  8'(bus.sri_done),  8'd1);
            chk("nom/hold_count", 8'(bus.sri_count), 8'd1);
        end
        set_req(1'b1);
        next_edge();
        chk("nom/exit_status", 8'(bus.sri_status), 8'd0);
        chk("nom/exit_done",   8'(bus.sri_done),   8'd0);

        // Early withdraw: full sequence anyway, DONE for exactly one cycle.
        next_edge();
        seq("wd", 16'hFFFC, 2);
        next_edge();
        chk("wd/exit_status", 8'(bus.sri_status), 8'd0);
        chk("wd/exit_done",   8'(bus.sri_done),   8'd0);

        // Second request edge during RELEASE is dropped.
        seq("drop", 16'h0040, 3);
        set_req(1'b0);
        next_edge();
        chk("drop/hold_done", 8'(bus.sri_done), 8'd1);
        set_req(1'b1);
        next_edge();
        chk("drop/exit_status", 8'(bus.sri_status), 8'd0);
        next_edge();
        chk("drop/no_pulse", 8'(bus.sri_reset_n), 8'd1);
        chk("drop/idle_busy", 8'(bus.sri_busy),   8'd0);
        chk("drop/count",     8'(bus.sri_count),  8'd3);

        // Reset during cycle 2 of ASSERT.
        set_req(1'b0);
        next_edge();
        chk("mid/assert1", 8'(bus.sri_reset_n), 8'd0);
        next_edge();
        chk("mid/assert2", 8'(bus.sri_reset_n), 8'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid/reset_n", 8'(bus.sri_reset_n), 8'd1);
        chk("mid/count",   8'(bus.sri_count),   8'd0);
        chk("mid/busy",    8'(bus.sri_busy),    8'd0);
        chk("mid/status",  8'(bus.sri_status),  8'd0);
        set_req(1'b1);
        rst = 1'b0;
        next_edge();
        seq("mid_new", 16'h0000, 1);
        set_req(1'b1);
        next_edge();
        chk("mid_new/exit", 8'(bus.sri_status), 8'd0);

        // Saturation: sequences 2..17 since reset; count holds at 15.
        for (int n = 2; n <= 17; n++) begin
            seq("sat", 16'hFFFC, (n > 15) ? 15 : n);
            next_edge();
            chk("sat/idle", 8'(bus.sri_status), 8'd0);
        end
        chk("sat/final", 8'(bus.sri_count), 8'd15);

        // A=R=1 instance: one-cycle pulse, done two edges after the request edge.
        @(negedge clk);
        bus1.sri_req_n = 1'b0;
        next_edge();
        chk("ar1/k_reset_n", 8'(bus1.sri_reset_n), 8'd0);
        chk("ar1/k_busy",    8'(bus1.sri_busy),    8'd1);
        chk("ar1/k_status",  8'(bus1.sri_status),  8'd1);
        next_edge();
        chk("ar1/k1_reset_n", 8'(bus1.sri_reset_n), 8'd1);
        chk("ar1/k1_status",  8'(bus1.sri_status),  8'd2);
        chk("ar1/k1_done",    8'(bus1.sri_done),    8'd0);
        next_edge();
        chk("ar1/k2_done",   8'(bus1.sri_done),   8'd1);
        chk("ar1/k2_busy",   8'(bus1.sri_busy),   8'd0);
        chk("ar1/k2_count",  8'(bus1.sri_count),  8'd1);
        @(negedge clk);
        bus1.sri_req_n = 1'b1;
        next_edge();
        chk("ar1/exit", 8'(bus1.sri_status), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
